nibble_pack8: RTL and testbench

//  Write-side counterpart of the 8-way nibble selector: collects a stream of 4-bit nibbles into one
//  32-bit word, nibble k into bits [4k+3:4k]. A selector driven with sel=k reads back nibble k.

---
 rtl/nibble_pack8_pkg.sv | 19 +
 rtl/nibble_pack8_dec3to8.sv | 20 ++
 rtl/nibble_pack8.sv | 115 +++++++++++
 tb/tb_nibble_pack8.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_pack8_pkg.sv
// Shared sizes, FSM state encoding and small helpers for the nibble packer.
package nibble_pack8_pkg;

   localparam int NIB_W  = 4;
   localparam int SLOTS  = 8;
   localparam int SEL_W  = 3;
   localparam int WORD_W = NIB_W * SLOTS;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   // Nibbles held in a word closed this cycle: slots already filled plus the one arriving now.
   function automatic logic [3:0] fill_count(input logic [SEL_W-1:0] slot, input logic xfer);
      return {1'b0, slot} + {3'b000, xfer};
   endfunction

endpackage

// File: rtl/nibble_pack8_dec3to8.sv
// Slot index to one-hot nibble write enable; all zeros when no transfer happens.
module nibble_pack8_dec3to8
   import nibble_pack8_pkg::*;
(
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [SLOTS-1:0] onehot
);

   // One-hot decode gated by the transfer strobe
   always_comb begin
      onehot = {SLOTS{1'b0}};
      if (en) begin
         onehot[sel] = 1'b1;
      end else begin
         onehot = {SLOTS{1'b0}};
      end
   end

endmodule

// File: rtl/nibble_pack8.sv
// Packs a valid/ready stream of 4-bit nibbles into 32-bit words, slot k at [4k+3:4k],
// with flush support for partial words.
module nibble_pack8
   import nibble_pack8_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [NIB_W-1:0]  in_nib,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic [WORD_W-1:0] dataout,
   output logic [3:0]        out_cnt,
   output logic              out_valid,
   input  logic              out_ready
);

   state_t             state_r;
   logic [SEL_W-1:0]   slot_r;
   logic [WORD_W-1:0]  buf_r;
   logic [WORD_W-1:0]  dataout_r;
   logic [3:0]         out_cnt_r;
   logic               out_valid_r;

   logic               in_ready_s;
   logic               xfer_s;
   logic               close_s;
   logic [SLOTS-1:0]   wr_en_s;
   logic [WORD_W-1:0]  merged_s;

   // Only out_ready reaches in_ready combinationally; a held word blocks input until it drains
   always_comb begin
      in_ready_s = 1'b1;
      case (state_r)
         ST_FILL: in_ready_s = 1'b1;
         ST_FULL: in_ready_s = out_ready;
         default: in_ready_s = 1'b0;
      endcase
   end

   assign xfer_s = in_valid & in_ready_s;

   nibble_pack8_dec3to8 u_dec (
      .sel    (slot_r),
      .en     (xfer_s),
      .onehot (wr_en_s)
   );

   // Buffer as it will look once this cycle's nibble (if any) is written
   always_comb begin
      merged_s = buf_r;
      for (int k = 0; k < SLOTS; k++) begin
         if (wr_en_s[k]) begin
            merged_s[k*NIB_W +: NIB_W] = in_nib;
         end else begin
            merged_s[k*NIB_W +: NIB_W] = buf_r[k*NIB_W +: NIB_W];
         end
      end
   end

   // A word closes on the eighth nibble, or on flush when it would carry at least one nibble
   assign close_s = (xfer_s && (slot_r == SEL_W'(SLOTS - 1))) ||
                    (flush && ((slot_r != {SEL_W{1'b0}}) || xfer_s));

   // Packer FSM: slot counter, fill buffer and registered output word
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_FILL;
         slot_r      <= {SEL_W{1'b0}};
         buf_r       <= {WORD_W{1'b0}};
         dataout_r   <= {WORD_W{1'b0}};
         out_cnt_r   <= 4'd0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_FILL: begin
               if (close_s) begin
                  dataout_r   <= merged_s;
                  out_cnt_r   <= fill_count(slot_r, xfer_s);
                  out_valid_r <= 1'b1;
                  buf_r       <= {WORD_W{1'b0}};
                  slot_r      <= {SEL_W{1'b0}};
                  state_r     <= ST_FULL;
               end else if (xfer_s) begin
                  buf_r  <= merged_s;
                  slot_r <= slot_r + 3'd1;
               end
            end
            ST_FULL: begin
               // Buffer is empty here, so a nibble accepted during drain lands in slot 0
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= ST_FILL;
                  if (xfer_s) begin
                     buf_r  <= merged_s;
                     slot_r <= 3'd1;
                  end
               end
            end
            default: begin
               state_r     <= ST_FILL;
               slot_r      <= {SEL_W{1'b0}};
               buf_r       <= {WORD_W{1'b0}};
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign dataout   = dataout_r;
   assign out_cnt   = out_cnt_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_nibble_pack8.sv
// Directed bench for nibble_pack8: expected words queued when stimulus is driven,
// popped and compared whenever the DUT hands a word to the consumer.
module tb_nibble_pack8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_nib;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [31:0] dataout;
   logic [3:0]  out_cnt;
   logic        out_valid;
   logic        out_ready;

   typedef struct packed {
      logic [31:0] word;
      logic [3:0]  cnt;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   nibble_pack8 dut (
      .clk       (clk),
      .rst       (rst),
      .in_nib    (in_nib),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .dataout   (dataout),
      .out_cnt   (out_cnt),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference 8-way nibble selector, used for the loopback sweep
   function automatic logic [3:0] nib_sel(input logic [31:0] w, input logic [2:0] sel);
      case (sel)
         3'd0: return w[3:0];
         3'd1: return w[7:4];
         3'd2: return w[11:8];
         3'd3: return w[15:12];
         3'd4: return w[19:16];
         3'd5: return w[23:20];
         3'd6: return w[27:24];
         default: return w[31:28];
      endcase
   endfunction

   // Offer one nibble and hold it until accepted (bounded wait)
   task automatic push(input logic [3:0] n);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_nib   = n;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      if (!done) check("push_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   // Scoreboard consumer side: every word handed over must match the queue head
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_word", dataout, 32'hDEAD_BEEF ^ dataout);
         end else begin
            e = sb.pop_front();
            check("word", dataout, e.word);
            check("cnt", {28'd0, out_cnt}, {28'd0, e.cnt});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_nib    = 4'd0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_dataout", dataout, 32'd0);
      check("rst_out_cnt", {28'd0, out_cnt}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // 1: full word, back-to-back, out_valid lasts one cycle
      sb.push_back('{word: 32'h76543210, cnt: 4'd8});
      for (int i = 0; i < 8; i++) push(4'(i));
      @(negedge clk);
      check("t1_valid_hi", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      check("t1_valid_lo", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;

      // 2: backpressure holds the word and blocks input; drain overlaps with next word's first nibble
      out_ready = 1'b0;
      sb.push_back('{word: 32'h76543210, cnt: 4'd8});
      for (int i = 0; i < 8; i++) push(4'(i));
      in_valid = 1'b1;
      in_nib   = 4'h8;
      repeat (3) begin
         @(negedge clk);
         check("t2_in_ready", {31'd0, in_ready}, 32'd0);
         check("t2_hold", dataout, 32'h76543210);
         check("t2_valid", {31'd0, out_valid}, 32'd1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      sb.push_back('{word: 32'hFEDCBA98, cnt: 4'd8});
      for (int i = 8; i < 16; i++) push(4'(i));
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;

      // 3: flush alone with three nibbles, then flush on an empty buffer
      sb.push_back('{word: 32'h00000321, cnt: 4'd3});
      for (int i = 1; i < 4; i++) push(4'(i));
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("t3_empty_flush0", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check("t3_empty_flush1", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;

      // 4: flush together with a nibble transfer includes that nibble
      sb.push_back('{word: 32'h00004321, cnt: 4'd4});
      for (int i = 1; i < 4; i++) push(4'(i));
      flush = 1'b1;
      push(4'h4);
      flush = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;

      // 5: reset mid-word discards the partial buffer
      for (int i = 1; i < 6; i++) push(4'(i));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("t5_out_valid", {31'd0, out_valid}, 32'd0);
      check("t5_dataout", dataout, 32'd0);
      check("t5_out_cnt", {28'd0, out_cnt}, 32'd0);
      @(posedge clk);
      #1;
      sb.push_back('{word: 32'h89ABCDEF, cnt: 4'd8});
      for (int i = 0; i < 8; i++) push(4'(15 - i));
      repeat (3) @(negedge clk);

      // 6: loopback through a nibble selector; dataout is retained after drain
      check("t6_drained", {31'd0, out_valid}, 32'd0);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("t6_sel%0d", k), {28'd0, nib_sel(dataout, 3'(k))}, 32'(15 - k));
      end

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
